regfile_writeback_queue: RTL
============================

Name: regfile_writeback_queue

Overview:
- Writer-side companion to the processor register file: collects writeback requests from the ALU path and the load path, buffers them in a small FIFO, and drives the register file write port (RegWrite, write_reg, write_data) at most once per cycle.
- Provides two combinational bypass lookups so rs/rt reads see queued data not yet committed to the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- NUM_REGS, 8, number of implemented registers; addresses >= NUM_REGS are illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load-path writeback request.
- ld_ready  out  1  load-path request accepted this cycle.
- ld_reg  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load data.
- alu_valid  in  1  ALU-path writeback request.
- alu_ready  out  1  ALU-path request accepted this cycle.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- wb_en  in  1  permits a dequeue/write this cycle.
- RegWrite  out  1  register file write enable.
- write_reg  out  ADDR_W  register file write address.
- write_data  out  DATA_W  register file write data.
- byp_a_reg  in  ADDR_W  rs lookup address.
- byp_a_hit  out  1  a queued write to byp_a_reg exists.
- byp_a_data  out  DATA_W  youngest queued data for byp_a_reg.
- byp_b_reg  in  ADDR_W  rt lookup address.
- byp_b_hit  out  1  a queued write to byp_b_reg exists.
- byp_b_data  out  DATA_W  youngest queued data for byp_b_reg.
- count  out  clog2(DEPTH)+1  occupied entries.
- err_addr  out  1  registered one-cycle pulse for an illegal address.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears rd_ptr, wr_ptr, count and err_addr immediately; entry storage is don't-care.
  - RegWrite, write_reg, write_data, byp_*_hit and byp_*_data all read 0 while reset is low.
  - Reset during operation discards all queued writes.
- Handshake: a transfer occurs on the rising edge where valid&ready=1. Valid must be held until accepted; data is sampled on that edge.
- Arbitration (fixed priority, load first):
  - ld_ready = (count != DEPTH).
  - alu_ready = (count != DEPTH) && !ld_valid.
  - At most one enqueue per cycle. Ready must not depend on the same port's valid.
- Full: when count == DEPTH, both readies are 0, even if a dequeue happens that cycle.
- Illegal address (reg >= NUM_REGS):
  - The handshake still completes, but nothing is enqueued.
  - err_addr = 1 for exactly the following cycle.
- Write port: combinational from the head entry.
  - RegWrite = wb_en && (count != 0).
  - write_reg and write_data equal the head entry when count != 0, else 0.
  - The head pops on the edge where RegWrite = 1.
- Latency: a request accepted at edge k into an empty queue with wb_en=1 appears on the write port during cycle k+1 and is committed at edge k+1. There is no same-cycle passthrough.
- Count: enqueue only gives +1, dequeue only gives -1, both together leave count unchanged. Pointers wrap modulo DEPTH.
- Register 0 is not special; it is written like any other register.
- Bypass:
  - hit = any occupied entry (head included) whose reg equals the lookup address.
  - data = the youngest matching entry; 0 on a miss.
  - Purely combinational and unaffected by wb_en.
  - Entries enqueued on the current edge are not visible until after that edge.

Test Plan:
1. Reset, wb_en=1, alu_valid reg=3 data=0x5 for one cycle -> next cycle RegWrite=1, write_reg=3, write_data=0x5, count=1; following cycle RegWrite=0, count=0.
2. ld_valid reg=2 data=0xA and alu_valid reg=4 data=0xB held together -> cycle 1 ld_ready=1, alu_ready=0; ALU accepted the next cycle; write port shows reg 2 then reg 4 on consecutive cycles.
3. wb_en=0, five ALU requests to regs 1..5 -> four accepted, count=4, alu_ready=0 on the fifth; set wb_en=1 -> regs 1,2,3,4 written in order, fifth accepted after the first pop, pointers wrap correctly.
4. wb_en=0, queue r5=0x1 then r5=0x2, byp_a_reg=5, byp_b_reg=6 -> byp_a_hit=1, byp_a_data=0x2; byp_b_hit=0, byp_b_data=0.
5. alu_valid reg=9 data=0xFF -> alu_ready=1, err_addr=1 for one cycle, count unchanged, no RegWrite.
6. wb_en=0, three entries queued, then reset pulsed low mid-cycle -> count=0 and RegWrite=0 immediately; after release, enable wb_en -> no writes occur.

Source files
------------

// File: rtl/regfile_writeback_queue_if.sv
// Bundle of the writeback queue's request, register-file write and bypass signals.
// The slave modport is the queue itself; the master modport is whatever drives it.
interface regfile_writeback_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_reg;
  logic [DATA_W-1:0] ld_data;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;

  logic              wb_en;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;

  logic [ADDR_W-1:0] byp_a_reg;
  logic              byp_a_hit;
  logic [DATA_W-1:0] byp_a_data;
  logic [ADDR_W-1:0] byp_b_reg;
  logic              byp_b_hit;
  logic [DATA_W-1:0] byp_b_data;

  logic [CNT_W-1:0]  count;
  logic              err_addr;

  modport slave (
    input  ld_valid, ld_reg, ld_data,
    output ld_ready,
    input  alu_valid, alu_reg, alu_data,
    output alu_ready,
    input  wb_en,
    output RegWrite, write_reg, write_data,
    input  byp_a_reg, byp_b_reg,
    output byp_a_hit, byp_a_data, byp_b_hit, byp_b_data,
    output count, err_addr
  );

  modport master (
    output ld_valid, ld_reg, ld_data,
    input  ld_ready,
    output alu_valid, alu_reg, alu_data,
    input  alu_ready,
    output wb_en,
    input  RegWrite, write_reg, write_data,
    output byp_a_reg, byp_b_reg,
    input  byp_a_hit, byp_a_data, byp_b_hit, byp_b_data,
    input  count, err_addr
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Writeback FIFO between the ALU/load paths and the register file write port,
// with two combinational bypass lookups returning the youngest queued value.
module regfile_writeback_queue #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_REGS = 8
) (
  input logic                    clk,
  input logic                    reset,
  regfile_writeback_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err_addr;

  logic              w_full;
  logic              w_empty;
  logic              w_alu_ready;
  logic              w_ld_fire;
  logic              w_alu_fire;
  logic              w_fire;
  logic [ADDR_W-1:0] w_in_reg;
  logic [DATA_W-1:0] w_in_data;
  logic              w_legal;
  logic              w_enq;
  logic              w_deq;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Load path has fixed priority; readies never look at their own valid.
  assign w_alu_ready = !w_full && !bus.ld_valid;
  assign w_ld_fire   = bus.ld_valid && !w_full;
  assign w_alu_fire  = bus.alu_valid && w_alu_ready;
  assign w_fire      = w_ld_fire || w_alu_fire;
  assign w_in_reg    = w_ld_fire ? bus.ld_reg  : bus.alu_reg;
  assign w_in_data   = w_ld_fire ? bus.ld_data : bus.alu_data;
  assign w_legal     = (32'(w_in_reg) < NUM_REGS);
  assign w_enq       = w_fire && w_legal;
  assign w_deq       = bus.wb_en && !w_empty;

  assign bus.ld_ready   = !w_full;
  assign bus.alu_ready  = w_alu_ready;
  assign bus.RegWrite   = w_deq;
  assign bus.write_reg  = w_empty ? '0 : r_reg[r_rd_ptr];
  assign bus.write_data = w_empty ? '0 : r_data[r_rd_ptr];
  assign bus.count      = r_count;
  assign bus.err_addr   = r_err_addr;

  // Entry storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_reg[r_wr_ptr]  <= w_in_reg;
      r_data[r_wr_ptr] <= w_in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_err_addr <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_err_addr <= w_fire && !w_legal;
    end
  end

  logic [PTR_W-1:0]  w_idx;
  logic              w_a_hit;
  logic [DATA_W-1:0] w_a_data;
  logic              w_b_hit;
  logic [DATA_W-1:0] w_b_data;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    w_idx    = '0;
    w_a_hit  = 1'b0;
    w_a_data = '0;
    w_b_hit  = 1'b0;
    w_b_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if (r_reg[w_idx] == bus.byp_a_reg) begin
          w_a_hit  = 1'b1;
          w_a_data = r_data[w_idx];
        end
        if (r_reg[w_idx] == bus.byp_b_reg) begin
          w_b_hit  = 1'b1;
          w_b_data = r_data[w_idx];
        end
      end
    end
  end

  assign bus.byp_a_hit  = w_a_hit;
  assign bus.byp_a_data = w_a_data;
  assign bus.byp_b_hit  = w_b_hit;
  assign bus.byp_b_data = w_b_data;

endmodule
